// File: rtl/ram_ctrl_pkg.sv
// Shared sizing constants and FSM state encoding for the RAM512 port controller.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/ram512_port_ctrl.sv
// Request/response front end for a 512-word RAM512 with a combinational read
// port. Handles single-word writes, single-word reads with a held response,
// and a full zero-fill sweep triggered by clear_start.
module ram512_port_ctrl #(
  parameter int unsigned ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clear_start,
  output logic              busy,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  import ram_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic              ram_load_q, ram_load_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;

  // State and registered RAM/response outputs, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      ram_load_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ram_address_q <= ram_address_d;
      ram_in_q      <= ram_in_d;
      ram_load_q    <= ram_load_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  // Next-state logic; RAM controls are computed one cycle ahead so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ram_address_d = ram_address_q;
    ram_in_d      = ram_in_q;
    ram_load_d    = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = rsp_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d       = ST_CLEAR;
          cnt_d         = '0;
          ram_address_d = '0;
          ram_in_d      = '0;
          ram_load_d    = 1'b1;
        end else if (req_valid) begin
          ram_address_d = req_addr;
          ram_in_d      = req_wdata;
          if (req_we) begin
            state_d    = ST_WRITE;
            ram_load_d = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        rsp_data_d  = ram_out;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d         = cnt_q + 1'b1;
          ram_address_d = cnt_q + 1'b1;
          ram_load_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE) && !clear_start;
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign ram_in      = ram_in_q;
  assign ram_load    = ram_load_q;
  assign ram_address = ram_address_q;

endmodule

// File: tb/tb_ram512_port_ctrl.sv
// Directed bench for ram512_port_ctrl with a behavioural RAM512 attached.
module tb_ram512_port_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        clear_start;
  logic        busy;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [8:0]  ram_address;
  logic [15:0] ram_out;

  int n_tests = 0;
  int n_fail  = 0;

  ram512_port_ctrl #(
    .ADDR_W(9),
    .DATA_W(16)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .clear_start(clear_start),
    .busy       (busy),
    .ram_in     (ram_in),
    .ram_load   (ram_load),
    .ram_address(ram_address),
    .ram_out    (ram_out)
  );

  // RAM512: synchronous write on load, combinational read from address.
  logic [15:0] mem [512];
  always @(posedge CLK) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    check("wr_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    check("wr_drive", {5'd0, ram_load, busy, ram_address, ram_in}, {5'd0, 1'b1, 1'b1, a, d});
    tick();
    check("wr_done", {30'd0, ram_load, busy}, 32'd0);
  endtask

  task automatic do_read(input logic [8:0] a, input logic [15:0] exp);
    check("rd_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rd_addr", {21'd0, ram_load, rsp_valid, busy, ram_address}, {21'd0, 1'b0, 1'b0, 1'b1, a});
    tick();
    check($sformatf("rd_data[%0d]", a), {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, exp});
    tick();
    check("rd_done", {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    RST_N = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; clear_start = 1'b0;

    // Reset state, asserted between edges
    #2 RST_N = 1'b0;
    #1;
    check("rst_outputs", {4'd0, ram_load, ram_address, ram_in, rsp_valid, busy},
          32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    tick(); tick();
    @(negedge CLK) RST_N = 1'b1;
    tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // Write 0x1234 to 5, read back
    do_write(9'd5, 16'h1234);
    do_read(9'd5, 16'h1234);

    // Write i to every address back-to-back, then read all back
    for (int i = 0; i < 512; i++) do_write(9'(i), 16'(i));
    for (int i = 0; i < 512; i++) do_read(9'(i), 16'(i));

    // Held response on addr 7
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'd7;
    tick();
    req_valid = 1'b0;
    tick();
    check("hold_first", {14'd0, rsp_valid, req_ready, rsp_data}, {14'd0, 1'b1, 1'b0, 16'd7});
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_stable", {14'd0, rsp_valid, req_ready, rsp_data}, {14'd0, 1'b1, 1'b0, 16'd7});
    end
    rsp_ready = 1'b1;
    tick();
    check("hold_release", {30'd0, rsp_valid, busy}, 32'd0);

    // Fill 0xFFFF, then clear with a competing write request
    for (int i = 0; i < 512; i++) do_write(9'(i), 16'hFFFF);
    clear_start = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 9'd3; req_wdata = 16'hAAAA;
    #1;
    check("clr_prio_ready", {31'd0, req_ready}, 32'd0);
    tick();
    clear_start = 1'b0; req_valid = 1'b0;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 600) begin
      if ({ram_load, ram_address, ram_in} !== {1'b1, 9'(n), 16'h0000}) bad++;
      clear_start = (n == 200);
      tick();
      n++;
    end
    clear_start = 1'b0;
    check("clr_busy_cycles", n, 32'd512);
    check("clr_drive_bad", bad, 32'd0);
    check("clr_end", {21'd0, busy, ram_load, ram_address}, {21'd0, 1'b0, 1'b0, 9'd511});
    tick();
    check("clr_no_queue", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 512; i++) do_read(9'(i), 16'h0000);

    // Reset in the middle of a clear sweep
    for (int i = 0; i < 512; i++) do_write(9'(i), 16'hFFFF);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (ram_address !== 9'd100 && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach100", {23'd0, ram_address}, 32'd100);
    #2 RST_N = 1'b0;
    #1;
    check("abort_async", {20'd0, ram_load, busy, rsp_valid, ram_address}, 32'd0);
    tick();
    @(negedge CLK) RST_N = 1'b1;
    tick();
    check("abort_ready", {30'd0, req_ready, busy}, 32'd2);
    tick();
    check("abort_no_resume", {30'd0, busy, ram_load}, 32'd0);
    for (int i = 0; i < 512; i++) begin
      if (i < 100) do_read(9'(i), 16'h0000);
      else if (i > 100) do_read(9'(i), 16'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
